// File: rtl/word_split_if.sv
// word_split_if: word-in / byte-out handshake bundle for word_split.
//   word_in, word_valid, word_ready : word side (producer -> splitter)
//   byte_out, byte_valid, byte_ready,
//   byte_last                       : byte side (splitter -> consumer)
//   busy                            : splitter holds a word not yet fully emitted
// Modports: slave = the splitter itself, master = the surrounding environment.
interface word_split_if #(
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;
  logic              busy;

  modport slave (
    input  word_in, word_valid, byte_ready,
    output word_ready, byte_out, byte_valid, byte_last, busy
  );

  modport master (
    output word_in, word_valid, byte_ready,
    input  word_ready, byte_out, byte_valid, byte_last, busy
  );
endinterface

// File: rtl/word_split.sv
// word_split: breaks one MU0 memory word into a stream of bytes.
// Default order is high byte then low byte; LSB_FIRST=1 reverses it.
// One word is held at a time; a new word is taken only in IDLE.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : word_split_if.slave (word side in, byte side out, busy)
// Optional build macro: WORD_SPLIT_CHKSUM_EN appends a third byte,
// high XOR low, and moves byte_last onto it.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | nothing held, word_ready=1
// S_FIRST  | first byte on byte_out, waiting for byte_ready
// S_SECOND | second byte on byte_out, waiting for byte_ready
// S_CHK    | checksum byte on byte_out (WORD_SPLIT_CHKSUM_EN only)
module word_split #(
  parameter bit LSB_FIRST = 1'b0,
  parameter int WORD_W    = 16,
  parameter int BYTE_W    = 8
) (
  input  logic    clock,
  input  logic    reset_n,
  word_split_if.slave bus
);

  generate
    if (WORD_W != 2 * BYTE_W) begin : g_cfg_err
      $error("word_split: WORD_W must equal 2*BYTE_W");
    end
  endgenerate

`ifdef WORD_SPLIT_CHKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q,  word_d;
  logic [BYTE_W-1:0] byte_q,  byte_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;

  logic [BYTE_W-1:0] in_hi, in_lo, held_hi, held_lo;
  logic [BYTE_W-1:0] first_in, second_held;

  assign in_hi       = bus.word_in[WORD_W-1:BYTE_W];
  assign in_lo       = bus.word_in[BYTE_W-1:0];
  assign held_hi     = word_q[WORD_W-1:BYTE_W];
  assign held_lo     = word_q[BYTE_W-1:0];
  // The first byte comes straight from word_in so it is valid the cycle after accept.
  assign first_in    = LSB_FIRST ? in_lo : in_hi;
  assign second_held = LSB_FIRST ? held_hi : held_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (bus.word_valid) begin
          word_d  = bus.word_in;
          byte_d  = first_in;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (bus.byte_ready) begin
          byte_d  = second_held;
`ifdef WORD_SPLIT_CHKSUM_EN
          last_d  = 1'b0;
`else
          last_d  = 1'b1;
`endif
          state_d = S_SECOND;
        end
      end
      S_SECOND: begin
        if (bus.byte_ready) begin
`ifdef WORD_SPLIT_CHKSUM_EN
          byte_d  = held_hi ^ held_lo;
          last_d  = 1'b1;
          state_d = S_CHK;
`else
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef WORD_SPLIT_CHKSUM_EN
      S_CHK: begin
        if (bus.byte_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // word_ready depends only on registered state, never on byte_ready.
  assign bus.word_ready = (state_q == S_IDLE);
  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.byte_last  = last_q;
  assign bus.busy       = valid_q;

endmodule

// File: tb/tb_word_split.sv
// Bench for word_split: an MSB-first and an LSB-first instance share the
// same stimulus; a negedge monitor checks both against a byte-list model.
module tb_word_split;

`ifdef WORD_SPLIT_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] word_in_s = '0;
  logic word_valid_s = 1'b0;
  logic byte_ready_s = 1'b0;
  bit   rand_rdy = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  word_split_if #(.WORD_W(16), .BYTE_W(8)) bus0 ();
  word_split_if #(.WORD_W(16), .BYTE_W(8)) bus1 ();

  assign bus0.word_in    = word_in_s;
  assign bus0.word_valid = word_valid_s;
  assign bus0.byte_ready = byte_ready_s;
  assign bus1.word_in    = word_in_s;
  assign bus1.word_valid = word_valid_s;
  assign bus1.byte_ready = byte_ready_s;

  word_split #(.LSB_FIRST(1'b0), .WORD_W(16), .BYTE_W(8)) u_msb (
    .clock(clock), .reset_n(reset_n), .bus(bus0));
  word_split #(.LSB_FIRST(1'b1), .WORD_W(16), .BYTE_W(8)) u_lsb (
    .clock(clock), .reset_n(reset_n), .bus(bus1));

  // One entry per expected byte: b0 for the MSB-first unit, b1 for LSB-first.
  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       last;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is just a list of bytes in emission order.
  function automatic void model_word(input logic [15:0] w);
    logic [7:0] hi, lo;
    exp_t e;
    hi = w[15:8];
    lo = w[7:0];
    e.b0 = hi; e.b1 = lo; e.last = 1'b0; q.push_back(e);
    e.b0 = lo; e.b1 = hi; e.last = !CHK;  q.push_back(e);
    if (CHK) begin
      e.b0 = hi ^ lo; e.b1 = hi ^ lo; e.last = 1'b1; q.push_back(e);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        automatic bit held = (q.size() != 0);
        chk("word_ready_msb", {15'd0, bus0.word_ready}, {15'd0, !held});
        chk("word_ready_lsb", {15'd0, bus1.word_ready}, {15'd0, !held});
        chk("byte_valid_msb", {15'd0, bus0.byte_valid}, {15'd0, held});
        chk("byte_valid_lsb", {15'd0, bus1.byte_valid}, {15'd0, held});
        chk("busy_msb",       {15'd0, bus0.busy},       {15'd0, held});
        chk("busy_lsb",       {15'd0, bus1.busy},       {15'd0, held});
        if (held) begin
          chk("byte_msb", {8'd0, bus0.byte_out}, {8'd0, q[0].b0});
          chk("byte_lsb", {8'd0, bus1.byte_out}, {8'd0, q[0].b1});
          chk("last_msb", {15'd0, bus0.byte_last}, {15'd0, q[0].last});
          chk("last_lsb", {15'd0, bus1.byte_last}, {15'd0, q[0].last});
          if (byte_ready_s) void'(q.pop_front());
        end else if (word_valid_s) begin
          model_word(word_in_s);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_rdy) byte_ready_s = 1'($urandom_range(0, 1));
    end
  end

  // Present a word and hold it until taken; leaves inputs at posedge+1.
  task automatic send_word(input logic [15:0] w);
    int n;
    word_in_s = w;
    word_valid_s = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus0.word_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL accept_timeout actual=busy required=ready word=%h", w);
    end
    @(posedge clock);
    #1;
    word_valid_s = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0 bytes pending", q.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_byte_out",   {8'd0, bus0.byte_out},     16'h0000);
    chk("rst_byte_valid", {15'd0, bus0.byte_valid},  16'h0000);
    chk("rst_byte_last",  {15'd0, bus0.byte_last},   16'h0000);
    chk("rst_busy",       {15'd0, bus0.busy},        16'h0000);
    chk("rst_word_ready", {15'd0, bus0.word_ready},  16'h0001);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic split, consumer always ready
    byte_ready_s = 1'b1;
    send_word(16'hA53C);
    wait_drain();

    // Back-pressure for 5 cycles on the first byte
    byte_ready_s = 1'b0;
    send_word(16'h1234);
    repeat (5) @(posedge clock);
    #1;
    byte_ready_s = 1'b1;
    wait_drain();

    // Zero byte is emitted
    send_word(16'h00FF);
    wait_drain();

    // Second word presented while first is in flight, word_in changed mid-word
    send_word(16'h1111);
    send_word(16'h2222);
    wait_drain();

    // Checksum vector (plain two bytes in the default build)
    send_word(16'hF00F);
    wait_drain();

    // Asynchronous reset while the first byte is stalled
    byte_ready_s = 1'b0;
    send_word(16'hABCD);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid_msb", {15'd0, bus0.byte_valid}, 16'h0000);
    chk("midrst_valid_lsb", {15'd0, bus1.byte_valid}, 16'h0000);
    chk("midrst_byte",      {8'd0, bus0.byte_out},    16'h0000);
    chk("midrst_ready",     {15'd0, bus0.word_ready}, 16'h0001);
    q.delete();
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    byte_ready_s = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("post_rst_valid", {15'd0, bus0.byte_valid}, 16'h0000);
    chk("post_rst_ready", {15'd0, bus0.word_ready}, 16'h0001);

    // Random words, gaps and back-pressure
    rand_rdy = 1'b1;
    repeat (300) begin
      automatic int gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
      send_word(16'($urandom));
    end
    rand_rdy = 1'b0;
    @(posedge clock);
    #2;
    byte_ready_s = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
